// File: rtl/ryl19_cntr_top.sv
// 8-bit up/down counter with clear, parallel load, wrap/saturate modes and a
// 4-way tick prescaler, wrapped for the Tiny Tapeout user-project pinout.
module ryl19_cntr_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = 8;
  localparam int unsigned PreW = 4;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PreW-1:0] pre_q, pre_d;

  logic       en_c, up_c, load_c, clear_c, sat_c;
  logic [1:0] psel_c;
  logic       tick_c;
  logic       unused_ui7;

  assign en_c       = ui_in[0];
  assign up_c       = ui_in[1];
  assign load_c     = ui_in[2];
  assign clear_c    = ui_in[3];
  assign sat_c      = ui_in[4];
  assign psel_c     = ui_in[6:5];
  assign unused_ui7 = ui_in[7];

  // Tick is decided on the prescaler value before this edge's increment.
  always_comb begin
    tick_c = 1'b0;
    unique case (psel_c)
      2'b00: tick_c = 1'b1;
      2'b01: tick_c = pre_q[0];
      2'b10: tick_c = &pre_q[1:0];
      2'b11: tick_c = &pre_q;
      default: tick_c = 1'b0;
    endcase
  end

  // Next-state: ena gate, then clear > load > enabled count.
  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (ena) begin
      if (clear_c) begin
        cnt_d = '0;
        pre_d = '0;
      end else if (load_c) begin
        cnt_d = uio_in;
        pre_d = '0;
      end else if (en_c) begin
        pre_d = pre_q + PreW'(1);
        if (tick_c) begin
          if (up_c) begin
            if (!(sat_c && (cnt_q == {CntW{1'b1}}))) cnt_d = cnt_q + CntW'(1);
          end else begin
            if (!(sat_c && (cnt_q == '0))) cnt_d = cnt_q - CntW'(1);
          end
        end
      end
    end
  end

  // rst_n is an active-high synchronous reset on this pin.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

  assign uo_out  = cnt_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_ryl19_cntr_top.sv
// Directed plus randomized bench for ryl19_cntr_top against an integer model.
module tb_ryl19_cntr_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;

  int m_cnt = 0;
  int m_pre = 0;
  int period [4] = '{1, 2, 4, 16};

  ryl19_cntr_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: arithmetic on integers straight from the rules.
  task automatic model_edge(input logic r, input logic e, input logic [7:0] u,
                            input logic [7:0] ld);
    int per;
    if (r) begin
      m_cnt = 0; m_pre = 0;
    end else if (!e) begin
      // hold
    end else if (u[3]) begin
      m_cnt = 0; m_pre = 0;
    end else if (u[2]) begin
      m_cnt = int'(ld); m_pre = 0;
    end else if (u[0]) begin
      per = period[u[6:5]];
      if (((m_pre + 1) % per) == 0) begin
        if (u[1]) m_cnt = u[4] ? ((m_cnt == 255) ? 255 : m_cnt + 1) : (m_cnt + 1) % 256;
        else      m_cnt = u[4] ? ((m_cnt == 0) ? 0 : m_cnt - 1) : (m_cnt + 255) % 256;
      end
      m_pre = (m_pre + 1) % 16;
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [7:0] u, input logic [7:0] ld);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = u;
    uio_in = ld;
    @(posedge clk);
    model_edge(r, e, u, ld);
    #1;
    chk("model", uo_out, 8'(m_cnt));
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

    cyc(1, 0, 8'h00, 8'h00);
    cyc(1, 0, 8'h00, 8'h00);
    chk("reset_cnt", uo_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);
    chk("uio_out", uio_out, 8'h00);

    repeat (5) cyc(0, 1, 8'h03, 8'h00);
    chk("count_up5", uo_out, 8'h05);

    cyc(0, 1, 8'h04, 8'hFE); chk("load_fe", uo_out, 8'hFE);
    cyc(0, 1, 8'h03, 8'h00); chk("wrap_up0", uo_out, 8'hFF);
    cyc(0, 1, 8'h03, 8'h00); chk("wrap_up1", uo_out, 8'h00);
    cyc(0, 1, 8'h03, 8'h00); chk("wrap_up2", uo_out, 8'h01);

    cyc(0, 1, 8'h04, 8'h01); chk("load_01", uo_out, 8'h01);
    cyc(0, 1, 8'h01, 8'h00); chk("wrap_dn0", uo_out, 8'h00);
    cyc(0, 1, 8'h01, 8'h00); chk("wrap_dn1", uo_out, 8'hFF);
    cyc(0, 1, 8'h01, 8'h00); chk("wrap_dn2", uo_out, 8'hFE);

    cyc(0, 1, 8'h04, 8'hFD);
    cyc(0, 1, 8'h13, 8'h00); chk("sat_up0", uo_out, 8'hFE);
    cyc(0, 1, 8'h13, 8'h00); chk("sat_up1", uo_out, 8'hFF);
    repeat (3) cyc(0, 1, 8'h13, 8'h00);
    chk("sat_up_hold", uo_out, 8'hFF);

    cyc(0, 1, 8'h04, 8'h02);
    cyc(0, 1, 8'h11, 8'h00); chk("sat_dn0", uo_out, 8'h01);
    cyc(0, 1, 8'h11, 8'h00); chk("sat_dn1", uo_out, 8'h00);
    repeat (2) cyc(0, 1, 8'h11, 8'h00);
    chk("sat_dn_hold", uo_out, 8'h00);

    cyc(0, 1, 8'h08, 8'h00);
    cyc(0, 1, 8'h23, 8'h00); chk("ps2_first", uo_out, 8'h00);
    cyc(0, 1, 8'h23, 8'h00); chk("ps2_second", uo_out, 8'h01);
    repeat (6) cyc(0, 1, 8'h23, 8'h00);
    chk("ps2_total", uo_out, 8'h04);

    cyc(0, 1, 8'h08, 8'h00);
    repeat (8) cyc(0, 1, 8'h43, 8'h00);
    chk("ps4_total", uo_out, 8'h02);

    cyc(0, 1, 8'h08, 8'h00);
    repeat (15) cyc(0, 1, 8'h63, 8'h00);
    chk("ps16_edge15", uo_out, 8'h00);
    cyc(0, 1, 8'h63, 8'h00); chk("ps16_edge16", uo_out, 8'h01);
    repeat (16) cyc(0, 1, 8'h63, 8'h00);
    chk("ps16_edge32", uo_out, 8'h02);

    cyc(0, 1, 8'h0C, 8'h55); chk("clear_beats_load", uo_out, 8'h00);
    cyc(0, 1, 8'h04, 8'h55); chk("load_no_en", uo_out, 8'h55);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 8'h03, 8'h00);
      chk("ena_hold", uo_out, 8'h55);
    end
    cyc(1, 0, 8'h03, 8'h00); chk("rst_over_ena", uo_out, 8'h00);

    cyc(0, 1, 8'h03, 8'h00); chk("gate0", uo_out, 8'h01);
    cyc(0, 1, 8'h02, 8'h00); chk("gate1", uo_out, 8'h01);
    cyc(0, 1, 8'h03, 8'h00); chk("gate2", uo_out, 8'h02);
    cyc(0, 1, 8'h02, 8'h00); chk("gate3", uo_out, 8'h02);

    // Random traffic: load/clear/reset kept rare so counting dominates.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] u;
      logic       r, e;
      u = 8'($urandom);
      if ($urandom_range(0, 9) != 0) u[3:2] = 2'b00;
      if ($urandom_range(0, 3) != 0) u[0] = 1'b1;
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      cyc(r, e, u, 8'($urandom));
    end
    chk("final_oe", uio_oe, 8'h00);
    chk("final_out", uio_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ryl19_cntr_top.md
Name: ryl19_cntr_top

Overview:
- Configurable 8-bit up/down counter in the Tiny Tapeout user-project wrapper.
- Features: enable, direction, synchronous clear, parallel load from the bidirectional pins, wrap or saturate mode, and a 4-way tick prescaler.
- The count is driven directly on the dedicated outputs.
- Top-level user module; all control comes from the chip pins.

Parameters:
- none (the width is fixed at 8 bits by the pin interface)

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-high (port name kept per pin convention; asserted when rst_n=1)
- ena  input  1  design-select; when 0, all state holds (except reset)
- ui_in  input  8  controls:
  - [0] en: count enable
  - [1] up: 1=up, 0=down
  - [2] load
  - [3] clear
  - [4] sat: 1=saturate, 0=wrap
  - [6:5] psel: prescale select
  - [7] unused, ignored
- uo_out  output  8  current count register value
- uio_in  input  8  parallel load value
- uio_out  output  8  constant 8'h00
- uio_oe  output  8  constant 8'h00 (all uio pins are inputs)

Behaviour:
- State:
  - cnt[7:0]: count register
  - pre[3:0]: prescaler counter
- Outputs:
  - uo_out = cnt, driven combinationally from the register with no extra pipeline stage.
  - A change is visible right after the rising edge on which it takes effect.
- Reset (rst_n=1 at a rising edge) sets cnt=0 and pre=0. This overrides all other inputs, including ena=0.
- Update priority each rising edge when reset is not asserted:
  1. ena=0: cnt and pre hold.
  2. clear=1: cnt=0, pre=0.
  3. load=1: cnt=uio_in, pre=0.
  4. en=1: pre=pre+1 (4-bit wrap). If tick=1, cnt steps once.
  5. Otherwise cnt and pre hold.
- Clear and load do not depend on en or the prescaler.
- Clear beats load when both are asserted in the same cycle.
- tick is evaluated on the current (pre-increment) pre value:
  - psel=00: always 1 (step every enabled cycle)
  - psel=01: pre[0]==1 (every 2nd enabled cycle)
  - psel=10: pre[1:0]==2'b11 (every 4th)
  - psel=11: pre[3:0]==4'hF (every 16th)
- Step rules:
  - up=1: cnt+1. At 8'hFF: wrap mode → 8'h00; sat mode → stays 8'hFF.
  - up=0: cnt-1. At 8'h00: wrap mode → 8'hFF; sat mode → stays 8'h00.
- A saturated hold still advances pre. The prescaler is never affected by the count value.
- Changing up, sat or psel mid-count takes effect on the next edge. pre is not reset by a psel change.
- Dropping en holds both cnt and pre. Re-enabling resumes the prescaler phase.
- Reset asserted mid-count: cnt=0 on that edge. Counting resumes on the first edge after rst_n returns to 0.
- No combinational path from any input to uo_out. uio_out and uio_oe are constant.

Test Plan:
- Reset and count-up:
  - Stimulus: rst_n=1 for 2 cycles → uo_out=0x00, uio_oe=0x00, uio_out=0x00. Then rst_n=0, ena=1, ui_in=0b0000_0011 (en, up, psel=00, wrap) for 5 cycles.
  - Required: uo_out=0x05.
- Load and wrap both directions:
  - uio_in=0xFE, pulse load → 0xFE. Count up 3 cycles in wrap mode → 0xFF, 0x00, 0x01.
  - Load 0x01, count down 3 cycles → 0x00, 0xFF, 0xFE.
- Saturation:
  - Load 0xFD, sat=1, up for 5 cycles → 0xFE, 0xFF, 0xFF, 0xFF, 0xFF.
  - Load 0x02, down for 4 cycles → 0x01, 0x00, 0x00, 0x00.
- Prescaler:
  - After clear, psel=01, en=1, up for 8 cycles → 0x04, with first change on the 2nd enabled edge.
  - psel=10 for 8 cycles from clear → 0x02.
  - psel=11 for 32 cycles → 0x02, with increments on the 16th and 32nd edges.
- Priority and holds:
  - clear=1 and load=1 with uio_in=0x55 on the same edge → 0x00.
  - load=1 with en=0 → 0x55.
  - ena=0 with en=1, up → holds 0x55 for 10 cycles.
  - rst_n=1 while ena=0 → 0x00.
- Enable gating:
  - en toggled 1,0,1,0 with psel=00 and up → count advances only on en=1 edges: 0x01, 0x01, 0x02, 0x02.
